alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX issue register feeding the 32-bit ALU. It produces the ALU's 4-bit operation code and both operands.
- Decodes the main-control ALU op class plus the R-type funct field into the ALU code set: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Registers everything behind a valid/ready handshake with stall and flush support.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- CTRL_W, 4, ALU operation code width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present from ID.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 reserved.
- funct  in  6  R-type function field.
- alu_src  in  1  1 selects imm as operand B.
- rs_addr  in  REG_AW  source register A.
- rt_addr  in  REG_AW  source register B.
- rs_data  in  DATA_W  register-file read A.
- rt_data  in  DATA_W  register-file read B.
- imm  in  DATA_W  sign-extended immediate.
- exmem_regwrite  in  1  EX/MEM stage writes a register.
- exmem_rd  in  REG_AW  EX/MEM destination.
- exmem_result  in  DATA_W  EX/MEM result.
- memwb_regwrite  in  1  MEM/WB stage writes a register.
- memwb_rd  in  REG_AW  MEM/WB destination.
- memwb_result  in  DATA_W  MEM/WB writeback value.
- flush  in  1  squash held and incoming instruction.
- out_ready  in  1  EX consumer accepts.
- out_valid  out  1  registered outputs are valid.
- alu_control  out  CTRL_W  registered ALU operation code.
- alu_a  out  DATA_W  registered operand A.
- alu_b  out  DATA_W  registered operand B.
- illegal  out  1  registered unsupported op/funct flag.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_control=0010, alu_a=0, alu_b=0, illegal=0. Outputs hold these values until the first accepted load after rst_n rises.
- in_ready = !out_valid || out_ready. This is combinational; no combinational path from in_valid to in_ready.
- Load occurs when in_valid && in_ready && !flush. On the next rising edge out_valid=1 and all registers take the decoded/forwarded values. Latency is 1 cycle.
- Drain with no load: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0 next cycle. Data registers hold.
- Stall: out_valid && !out_ready -> all outputs hold exactly, in_ready=0.
- Flush has highest priority. out_valid=0 next cycle, the incoming instruction is discarded, and data registers hold. A flush coinciding with a stall also clears out_valid.
- Decode:
  - alu_op 00 -> 0010.
  - alu_op 01 -> 0110.
  - alu_op 10 with funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111.
  - Any other funct with alu_op 10, or alu_op 11 -> alu_control=0010, illegal=1.
  - The instruction is still issued (out_valid=1); trapping is downstream.
- Forwarding for operand A is evaluated at load time, using these sources in priority order:
  1. exmem_result if exmem_regwrite && exmem_rd!=0 && exmem_rd==rs_addr.
  2. Else memwb_result if memwb_regwrite && memwb_rd!=0 && memwb_rd==rs_addr.
  3. Else rs_data.
- Forwarded B source uses the same rule with rt_addr/rt_data.
- alu_b = alu_src ? imm : forwarded B. Immediate is never replaced by forwarding.
- Register 0 is never forwarded, regardless of regwrite.
- No arithmetic in this block; widths pass through unchanged.

Test Plan:
- Reset and first load: assert rst_n=0 mid-operation with out_valid=1 -> out_valid=0, alu_control=0010 immediately (async). Release reset, present R-type funct 100100, rs_data=0xF0F0F0F0, rt_data=0x0FF00FF0 -> one cycle later alu_control=0000, alu_a=0xF0F0F0F0, alu_b=0x0FF00FF0, out_valid=1.
- Decode sweep: alu_op 00/01 and funct 100000/100010/100100/100101/101010 -> codes 0010/0110/0010/0110/0000/0001/0111, illegal=0. Then alu_op 11 and funct 000000 with alu_op 10 -> alu_control=0010, illegal=1.
- Forwarding priority:
  - rs_addr=5, exmem_rd=5, memwb_rd=5, both regwrite=1, exmem_result=0x11, memwb_result=0x22 -> alu_a=0x11.
  - Drop exmem_regwrite -> alu_a=0x22.
  - rs_addr=0 with matching rd=0 -> alu_a=rs_data.
- Immediate select: alu_src=1, imm=0xFFFFFFFC, rt_addr matches exmem_rd -> alu_b=0xFFFFFFFC.
- Backpressure: hold out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and outputs unchanged. Raise out_ready with in_valid=1 -> new instruction replaces old in the same edge (back-to-back throughput 1/cycle).
- Flush: flush=1 with out_valid=1, out_ready=0, in_valid=1 -> out_valid=0 next cycle and the incoming op is not loaded. Next cycle in_ready=1.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: ID-to-EX issue bus between decode, the issue register and the ALU.
interface alu_issue_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              alu_src;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  logic              exmem_regwrite;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_regwrite;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              illegal;
  modport master (
    output in_valid, alu_op, funct, alu_src, rs_addr, rt_addr, rs_data, rt_data, imm,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
           flush, out_ready,
    input  in_ready, out_valid, alu_control, alu_a, alu_b, illegal
  );
  modport slave (
    input  in_valid, alu_op, funct, alu_src, rs_addr, rt_addr, rs_data, rt_data, imm,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
           flush, out_ready,
    output in_ready, out_valid, alu_control, alu_a, alu_b, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register with ALU decode, operand forwarding and valid/ready handshake.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus_io
);
  logic              valid_q, valid_d, illegal_q, illegal_d, load;
  logic              ex_a, mw_a, ex_b, mw_b;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  assign bus_io.in_ready = !valid_q || bus_io.out_ready;
  assign load = bus_io.in_valid && bus_io.in_ready && !bus_io.flush;
  // register 0 is hardwired, so a write to it never forwards
  assign ex_a = bus_io.exmem_regwrite && bus_io.exmem_rd != '0 && bus_io.exmem_rd == bus_io.rs_addr;
  assign mw_a = bus_io.memwb_regwrite && bus_io.memwb_rd != '0 && bus_io.memwb_rd == bus_io.rs_addr;
  assign ex_b = bus_io.exmem_regwrite && bus_io.exmem_rd != '0 && bus_io.exmem_rd == bus_io.rt_addr;
  assign mw_b = bus_io.memwb_regwrite && bus_io.memwb_rd != '0 && bus_io.memwb_rd == bus_io.rt_addr;
  always_comb begin
    valid_d = bus_io.flush ? 1'b0 : load ? 1'b1 : valid_q && !bus_io.out_ready;
    a_d = ex_a ? bus_io.exmem_result : mw_a ? bus_io.memwb_result : bus_io.rs_data;
    b_d = bus_io.alu_src ? bus_io.imm : ex_b ? bus_io.exmem_result : mw_b ? bus_io.memwb_result : bus_io.rt_data;
    ctrl_d = 4'b0010;
    illegal_d = 1'b0;
    case (bus_io.alu_op)
      2'b00: ctrl_d = 4'b0010;
      2'b01: ctrl_d = 4'b0110;
      2'b10:
        case (bus_io.funct)
          6'b100000: ctrl_d = 4'b0010;
          6'b100010: ctrl_d = 4'b0110;
          6'b100100: ctrl_d = 4'b0000;
          6'b100101: ctrl_d = 4'b0001;
          6'b101010: ctrl_d = 4'b0111;
          default:   illegal_d = 1'b1;
        endcase
      default: illegal_d = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= 4'b0010;
      a_q       <= '0;
      b_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        ctrl_q    <= ctrl_d;
        a_q       <= a_d;
        b_q       <= b_d;
        illegal_q <= illegal_d;
      end
    end
  end
  assign bus_io.out_valid   = valid_q;
  assign bus_io.alu_control = ctrl_q;
  assign bus_io.alu_a       = a_q;
  assign bus_io.alu_b       = b_q;
  assign bus_io.illegal     = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for the ALU issue stage, directed scenarios then random traffic.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_issue_if vif ();
  alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus_io(vif));
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic        src;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exr;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwr;
  } stim_t;
  localparam exp_t RESET_VAL = '{ctrl: 4'b0010, a: 32'd0, b: 32'd0, ill: 1'b0};
  exp_t q[$];
  exp_t last = RESET_VAL;
  int checks = 0, errors = 0;
  logic [1:0] sw_op[9] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
  logic [5:0] sw_fn[9] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h20, 6'h00};
  logic [3:0] sw_cd[9] = '{4'h2, 4'h6, 4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'h2, 4'h2};
  logic       sw_il[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [5:0] legal_fn[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    if (r == 5'd0) return d;
    if (vif.exmem_regwrite && vif.exmem_rd == r) return vif.exmem_result;
    if (vif.memwb_regwrite && vif.memwb_rd == r) return vif.memwb_result;
    return d;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.ctrl = 4'b0010;
    e.ill = 1'b0;
    if (vif.alu_op == 2'b01) e.ctrl = 4'b0110;
    else if (vif.alu_op == 2'b11) e.ill = 1'b1;
    else if (vif.alu_op == 2'b10) begin
      case (vif.funct)
        6'h20: e.ctrl = 4'b0010;
        6'h22: e.ctrl = 4'b0110;
        6'h24: e.ctrl = 4'b0000;
        6'h25: e.ctrl = 4'b0001;
        6'h2a: e.ctrl = 4'b0111;
        default: e.ill = 1'b1;
      endcase
    end
    e.a = fwd(vif.rs_addr, vif.rs_data);
    e.b = vif.alu_src ? vif.imm : fwd(vif.rt_addr, vif.rt_data);
    return e;
  endfunction

  // The queue holds whatever the stage should currently be holding (0 or 1 entries).
  always @(negedge clk) begin : mon
    exp_t e;
    bit rdy;
    if (rst_n) begin
      rdy = q.size() == 0 || vif.out_ready;
      chk("out_valid", vif.out_valid, q.size() != 0);
      chk("in_ready", vif.in_ready, rdy);
      chk("held_outputs", {vif.alu_control, vif.alu_a, vif.alu_b, vif.illegal}, last);
      if (q.size() != 0 && vif.out_ready) begin
        e = q.pop_front();
        chk("transfer", {vif.alu_control, vif.alu_a, vif.alu_b, vif.illegal}, e);
      end else if (q.size() != 0 && vif.flush) void'(q.pop_front());
      if (vif.in_valid && rdy && !vif.flush) begin
        last = model();
        q.push_back(last);
      end
    end
  end

  function automatic stim_t zero_stim();
    stim_t s;
    s.op = 2'd0; s.fn = 6'd0; s.src = 1'b0; s.rs = 5'd0; s.rt = 5'd0;
    s.rsd = 32'd0; s.rtd = 32'd0; s.imm = 32'd0;
    s.exw = 1'b0; s.exrd = 5'd0; s.exr = 32'd0;
    s.mww = 1'b0; s.mwrd = 5'd0; s.mwr = 32'd0;
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.op = 2'($urandom_range(0, 3));
    s.fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
    s.src = 1'($urandom_range(0, 1));
    s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
    s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom;
    s.exw = 1'($urandom_range(0, 1)); s.exrd = 5'($urandom_range(0, 3)); s.exr = $urandom;
    s.mww = 1'($urandom_range(0, 1)); s.mwrd = 5'($urandom_range(0, 3)); s.mwr = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s, input bit v, input bit rdy, input bit fl);
    vif.in_valid = v; vif.out_ready = rdy; vif.flush = fl;
    vif.alu_op = s.op; vif.funct = s.fn; vif.alu_src = s.src;
    vif.rs_addr = s.rs; vif.rt_addr = s.rt; vif.rs_data = s.rsd; vif.rt_data = s.rtd; vif.imm = s.imm;
    vif.exmem_regwrite = s.exw; vif.exmem_rd = s.exrd; vif.exmem_result = s.exr;
    vif.memwb_regwrite = s.mww; vif.memwb_rd = s.mwrd; vif.memwb_result = s.mwr;
  endtask

  task automatic step(input stim_t s, input bit v, input bit rdy, input bit fl);
    drive(s, v, rdy, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    drive(zero_stim(), 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s = zero_stim();
    s.op = 2'b01; s.rsd = 32'h1234; s.rtd = 32'h5678;
    step(s, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_valid", vif.out_valid, 1'b1);
    drive(zero_stim(), 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {vif.out_valid, vif.alu_control, vif.alu_a, vif.alu_b, vif.illegal}, {1'b0, RESET_VAL});
    q.delete();
    last = RESET_VAL;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    s = zero_stim();
    s.op = 2'b10; s.fn = 6'b100100; s.rsd = 32'hF0F0F0F0; s.rtd = 32'h0FF00FF0;
    step(s, 1'b1, 1'b1, 1'b0);
    chk("first_load", {vif.out_valid, vif.alu_control, vif.alu_a, vif.alu_b}, {1'b1, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0});
    for (int i = 0; i < 9; i++) begin
      s = zero_stim();
      s.op = sw_op[i]; s.fn = sw_fn[i];
      step(s, 1'b1, 1'b1, 1'b0);
      chk($sformatf("decode_%0d", i), {vif.out_valid, vif.alu_control, vif.illegal}, {1'b1, sw_cd[i], sw_il[i]});
    end
    s = zero_stim();
    s.rs = 5'd5; s.rsd = 32'h33;
    s.exw = 1'b1; s.exrd = 5'd5; s.exr = 32'h11;
    s.mww = 1'b1; s.mwrd = 5'd5; s.mwr = 32'h22;
    step(s, 1'b1, 1'b1, 1'b0);
    chk("fwd_exmem_priority", vif.alu_a, 32'h11);
    s.exw = 1'b0;
    step(s, 1'b1, 1'b1, 1'b0);
    chk("fwd_memwb", vif.alu_a, 32'h22);
    s.rs = 5'd0; s.exw = 1'b1; s.exrd = 5'd0; s.mwrd = 5'd0; s.rsd = 32'h44;
    step(s, 1'b1, 1'b1, 1'b0);
    chk("fwd_r0_blocked", vif.alu_a, 32'h44);
    s = zero_stim();
    s.src = 1'b1; s.imm = 32'hFFFFFFFC; s.rt = 5'd7; s.rtd = 32'h66;
    s.exw = 1'b1; s.exrd = 5'd7; s.exr = 32'h55;
    step(s, 1'b1, 1'b1, 1'b0);
    chk("imm_select", vif.alu_b, 32'hFFFFFFFC);
    s = zero_stim();
    s.rsd = 32'hAAAA0001;
    for (int i = 0; i < 3; i++) begin
      step(s, 1'b1, 1'b0, 1'b0);
      chk($sformatf("stall_%0d", i), {vif.out_valid, vif.in_ready, vif.alu_b}, {1'b1, 1'b0, 32'hFFFFFFFC});
    end
    step(s, 1'b1, 1'b1, 1'b0);
    chk("stall_release", {vif.out_valid, vif.alu_a}, {1'b1, 32'hAAAA0001});
    s.rsd = 32'hBBBB0002;
    step(s, 1'b1, 1'b0, 1'b1);
    chk("flush_clears", {vif.out_valid, vif.alu_a}, {1'b0, 32'hAAAA0001});
    drive(s, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush_in_ready", vif.in_ready, 1'b1);
    for (int i = 0; i < 400; i++)
      step(rnd_stim(), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    repeat (3) step(zero_stim(), 1'b0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
